// File: rtl/qclk_gen.sv
// Multi-channel clock-divider: NCH registered square waves plus edge tick strobes.
// Define QCLK_GEN_RT_LOAD_EN to enable runtime half-period reloads (nxt/pend path).
module qclk_gen #(
  parameter int unsigned       NCH       = 2,
  parameter int unsigned       CW        = 27,
  parameter logic [NCH*CW-1:0] HALF_INIT = {27'd500, 27'd50000000}
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sync_clr,
  input  logic           ld_valid,
  input  logic [2:0]     ld_ch,
  input  logic [CW-1:0]  ld_half,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  logic [CW-1:0]  cnt  [NCH];
  logic [CW-1:0]  half [NCH];
  logic [NCH-1:0] term_c;

  // Terminal count: the current half-interval ends on this edge.
  always_comb begin
    term_c = '0;
    for (int i = 0; i < NCH; i++) begin
      term_c[i] = en && (cnt[i] == half[i] - CW'(1));
    end
  end

`ifdef QCLK_GEN_RT_LOAD_EN
  logic [CW-1:0]  nxt [NCH];
  logic [NCH-1:0] ld_hit;

  // Channel index compare also rejects out-of-range ld_ch (no channel matches).
  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      ld_hit[i] = ld_valid && (ld_half != '0) && (ld_ch == 3'(i));
    end
  end

  // A load coinciding with an edge or sync_clr is applied immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        half[i] <= HALF_INIT[i*CW +: CW];
        nxt[i]  <= HALF_INIT[i*CW +: CW];
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ld_hit[i]) begin
          nxt[i] <= ld_half;
        end
        if (sync_clr || term_c[i]) begin
          if (pend[i] || ld_hit[i]) begin
            half[i] <= ld_hit[i] ? ld_half : nxt[i];
          end
          pend[i] <= 1'b0;
        end else if (ld_hit[i]) begin
          pend[i] <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_ch, ld_half};
  assign pend      = '0;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      half[i] = HALF_INIT[i*CW +: CW];
    end
  end
`endif

  // Per-channel counter, square wave and tick; sync_clr dominates the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_clr) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (term_c[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= 1'b1;
        end else if (en) begin
          cnt[i]  <= cnt[i] + CW'(1);
          tick[i] <= 1'b0;
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qclk_gen.sv
// Scoreboard bench for qclk_gen: a remaining-cycles reference model pushes the
// expected outputs per cycle, popped and compared after each rising edge.
module tb_qclk_gen;
  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam logic [NCH*CW-1:0] HI = {8'd3, 8'd4};

  logic           clk = 1'b0;
  logic           rst_n, en, sync_clr, ld_valid;
  logic [2:0]     ld_ch;
  logic [CW-1:0]  ld_half;
  logic [NCH-1:0] clk_out, tick, pend;

  typedef struct packed {
    logic [1:0] co;
    logic [1:0] tk;
    logic [1:0] pd;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int         m_rem [2];
  int         m_half[2];
  int         m_nxt [2];
  logic [1:0] m_co, m_tk, m_pd;

  qclk_gen #(.NCH(NCH), .CW(CW), .HALF_INIT(HI)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_half(ld_half),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_half[0] = 4; m_half[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = m_half[i];
      m_nxt[i] = m_half[i];
    end
    m_co = '0; m_tk = '0; m_pd = '0;
  endtask

  // m_rem counts clk cycles left until the next output edge.
  task automatic model_step(input logic e, input logic c, input logic lv,
                            input logic [2:0] lc, input logic [7:0] lh);
    for (int i = 0; i < 2; i++) begin
      logic hit;
      hit = lv && (lc == 3'(i)) && (lh != 8'd0);
`ifndef QCLK_GEN_RT_LOAD_EN
      hit = 1'b0;
`endif
      if (c) begin
        if (m_pd[i] || hit) m_half[i] = hit ? int'(lh) : m_nxt[i];
        if (hit) m_nxt[i] = int'(lh);
        m_pd[i] = 1'b0; m_rem[i] = m_half[i]; m_co[i] = 1'b0; m_tk[i] = 1'b0;
      end else if (e) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_co[i] = ~m_co[i]; m_tk[i] = 1'b1;
          if (m_pd[i] || hit) m_half[i] = hit ? int'(lh) : m_nxt[i];
          if (hit) m_nxt[i] = int'(lh);
          m_pd[i] = 1'b0; m_rem[i] = m_half[i];
        end else begin
          m_tk[i] = 1'b0;
          if (hit) begin m_nxt[i] = int'(lh); m_pd[i] = 1'b1; end
        end
      end else begin
        m_tk[i] = 1'b0;
        if (hit) begin m_nxt[i] = int'(lh); m_pd[i] = 1'b1; end
      end
    end
  endtask

  task automatic cyc(input logic e, input logic c, input logic lv,
                     input logic [2:0] lc, input logic [7:0] lh);
    exp_t x;
    @(negedge clk);
    en = e; sync_clr = c; ld_valid = lv; ld_ch = lc; ld_half = lh;
    model_step(e, c, lv, lc, lh);
    sb_q.push_back('{co: m_co, tk: m_tk, pd: m_pd});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      x = sb_q.pop_front();
      check("clk_out", 32'(clk_out), 32'(x.co));
      check("tick",    32'(tick),    32'(x.tk));
      check("pend",    32'(pend),    32'(x.pd));
    end
  endtask

  initial begin
    int r0, r1;
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; ld_valid = 1'b0; ld_ch = '0; ld_half = '0;
    model_reset();
    #12;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pend",    32'(pend),    32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Free run from reset: ch0 edges every 4, ch1 every 3.
    r0 = 0; r1 = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc(1, 0, 0, 0, 0);
      if (clk_out[0] && r0 == 0) r0 = n;
      if (clk_out[1] && r1 == 0) r1 = n;
    end
    check("first_rise_ch0", 32'(r0), 32'd4);
    check("first_rise_ch1", 32'(r1), 32'd3);

    // Enable gap stretches the interval.
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 10; n++) cyc(1, 0, 0, 0, 0);

    // Phase-align, then runtime load ch1=6 one cycle after.
    cyc(1, 1, 0, 0, 0);
    check("clr_clk_out", 32'(clk_out), 32'd0);
    cyc(1, 0, 1, 1, 8'd6);
    for (int n = 0; n < 16; n++) cyc(1, 0, 0, 0, 0);

    // Last load wins; invalid loads ignored.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 8'd2);
    cyc(1, 0, 1, 0, 8'd7);
    for (int n = 0; n < 16; n++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 3'd5, 8'd9);
    cyc(1, 0, 1, 3'd1, 8'd0);
    for (int n = 0; n < 10; n++) cyc(1, 0, 0, 0, 0);

    // Randomised mix, including half=1 and loads coinciding with edges/clears.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 8) != 0, ($urandom % 25) == 0, ($urandom % 4) == 0,
          3'($urandom % 4), 8'($urandom % 6));
    end

    // Async reset mid-interval with a pending load.
    cyc(1, 1, 0, 0, 0);
    for (int n = 0; n < 8 && clk_out == '0; n++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 8'd9);
    #3 rst_n = 1'b0;
    #1;
    check("arst_clk_out", 32'(clk_out), 32'd0);
    check("arst_tick",    32'(tick),    32'd0);
    check("arst_pend",    32'(pend),    32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    en = 1'b0; sync_clr = 1'b0; ld_valid = 1'b0;
    for (int n = 0; n < 14; n++) cyc(1, 0, 0, 0, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qclk_gen.md
# qclk_gen

Parametrised multi-channel clock-divider generator. It produces NCH independent divided square waves plus one-cycle tick strobes from the single system clock. Each channel's half-period can be reloaded at runtime, and all channels share run/restart controls. Every output is registered in the `clk` domain, so downstream logic consumes `tick` as a clock enable rather than using derived clocks.

## Interface
- `NCH`, 2, number of channels (1..8).
- `CW`, 27, counter and half-period width in bits.
- `HALF_INIT`, {27'd500, 27'd50000000}, packed NCH×CW reset half-periods in clk cycles; channel i occupies bits [i*CW +: CW]; each field must be ≥1.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global run; when low, all counters hold.
- `sync_clr`  in  1  synchronous restart of all channels (phase alignment).
- `ld_valid`  in  1  half-period load request, one cycle.
- `ld_ch`  in  3  target channel of the load.
- `ld_half`  in  CW  new half-period in clk cycles.
- `clk_out`  out  NCH  divided square waves; period is 2×half.
- `tick`  out  NCH  one-cycle strobe on every `clk_out` edge.
- `pend`  out  NCH  a loaded half-period is waiting to be applied.

## Operation
- Per-channel state: `cnt[i]` (CW bits), active half-period `half[i]`, pending value `nxt[i]`, `pend[i]`, `clk_out[i]`, `tick[i]`.
- Reset values:
  - `cnt` = 0, `clk_out` = 0, `tick` = 0, `pend` = 0.
  - `half[i]` = HALF_INIT field i; `nxt[i]` = HALF_INIT field i.
- Terminal condition T[i] = `en` && (`cnt[i]` == `half[i]`−1).
- Per-cycle priority, highest first:
  1. `sync_clr`: `cnt` ← 0, `clk_out` ← 0, `tick` ← 0 on all channels. Any pending value moves into `half`, and `pend` ← 0.
  2. T[i]: `cnt[i]` ← 0, `clk_out[i]` toggles, `tick[i]` ← 1. If `pend[i]`, then `half[i]` ← `nxt[i]` and `pend[i]` ← 0.
  3. `en`: `cnt[i]` ← `cnt[i]`+1, `tick[i]` ← 0.
  4. `en` low: `cnt` and `clk_out` hold, `tick` ← 0.
- Load: when `ld_valid` is high, `ld_ch` < NCH and `ld_half` ≠ 0, then `nxt[ld_ch]` ← `ld_half` and `pend[ld_ch]` ← 1.
  - Out-of-range channel or zero value: the load is silently ignored.
  - Repeated loads before application: the last one wins.
- A load in the same cycle as T[i] or `sync_clr` applies at that event, so the new half governs the very next interval.
- Arithmetic is unsigned CW-bit. The counter never exceeds `half`−1 because `half` only changes when `cnt` returns to 0.

## Timing
- After reset release with `en` held high, the first `clk_out[i]` rise and `tick[i]` pulse appear registered exactly HALF cycles later.
- Each subsequent edge follows every HALF cycles.
- `tick[i]` is high for exactly one cycle, coincident with the `clk_out[i]` transition.
- With `half` = 1, the channel toggles every cycle and `tick` stays high continuously.
- `en` low for N cycles stretches the current interval by N cycles; no edge is lost or duplicated.
- `sync_clr` takes effect on the next edge. With `en` high, the first rise follows HALF cycles after the `sync_clr` cycle.
- `pend` asserts the cycle after an accepted load and clears on the edge that applies it.
- `rst_n` low mid-operation: all outputs return to their reset values immediately (asynchronously), and runtime loads are discarded.

## Configuration
- `QCLK_GEN_RT_LOAD_EN`
  - Defined: the runtime load path, `nxt` and `pend` are implemented as described above.
  - Undefined: `ld_valid`, `ld_ch` and `ld_half` are ignored, `pend` is tied to 0, and `half` is constant at HALF_INIT.

## Test plan
- NCH=2, CW=8, HALF_INIT ch0=4, ch1=3, `en`=1 from reset:
  - ch0 `clk_out` rises at cycle 4, falls at 8, and so on.
  - ch1 edges at cycles 3, 6, 9.
  - Each edge carries exactly one `tick` cycle.
- `en` low for 5 cycles in mid-interval -> the ch0 edge is delayed by exactly 5 cycles and no `tick` occurs while `en` is low.
- Load ch1=6 at cycle 1 -> `pend[1]`=1 until the cycle-3 edge, after which ch1 edges fall at cycles 9, 15.
- Loads ch0=2 then ch0=7 before the next terminal -> 7 is applied. Loads with `ld_ch`=5 or `ld_half`=0 -> no change and `pend` stays 0.
- `sync_clr` asserted while ch0 `clk_out`=1 and ch1 is mid-count -> both `clk_out`=0 the next cycle and both channels restart phase-aligned.
- `rst_n` pulsed low mid-interval with a pending load -> outputs clear immediately and `half` returns to HALF_INIT.
- With `QCLK_GEN_RT_LOAD_EN` undefined -> the same load stimulus has no effect.
